// File: rtl/video_frame_reader_if.sv
// Bus bundle for video_frame_reader: display-side pixel port and SDRAM burst-read port.
// Handshakes: read_req is a level held until the one-cycle read_req_ack; read_en pops one pixel, returned on
// read_data the following cycle; mem_req with stable mem_addr/mem_len is held until the one-cycle mem_gnt,
// after which exactly mem_len words arrive on cycles flagged by mem_rvalid.
interface video_frame_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 24
);
  logic                  read_req;
  logic                  read_req_ack;
  logic                  read_en;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [8:0]            mem_len;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  underflow;

  modport master (
    input  read_req, read_en, mem_gnt, mem_rvalid, mem_rdata,
    output read_req_ack, read_data, mem_req, mem_addr, mem_len, underflow
  );

  modport slave (
    output read_req, read_en, mem_gnt, mem_rvalid, mem_rdata,
    input  read_req_ack, read_data, mem_req, mem_addr, mem_len, underflow
  );
endinterface

// File: rtl/video_frame_reader.sv
// Frame-buffer read responder: per-frame read_req/ack handshake, SDRAM burst prefetch into a local FIFO, pixel pop.
// Optional macro FRAME_PINGPONG_EN: frame base alternates BASE_ADDR / BASE_ADDR+FRAME_WORDS on each ack.
module video_frame_reader #(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    ADDR_WIDTH  = 24,
  parameter int                    FIFO_AW     = 9,
  parameter int                    BURST_LEN   = 128,
  parameter int                    FRAME_WORDS = 130560,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                 video_clk,
  input  logic                 rst,
  video_frame_reader_if.master bus,
  output logic [2:0]           state_dbg
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CNT_W = $clog2(FRAME_WORDS + 1);
  localparam int FC_W  = FIFO_AW + 1;

  // state_dbg encoding: 0 IDLE, 1 ACK, 2 FILL, 3 BURST, 4 DRAIN, 5 DONE
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ACK   = 3'd1;
  localparam logic [2:0] FILL  = 3'd2;
  localparam logic [2:0] BURST = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]            state;
  logic [CNT_W-1:0]      issued;
  logic [8:0]            inflight;
  logic [8:0]            next_len;
  logic [31:0]           remaining;
  logic [31:0]           need;
  logic [FC_W-1:0]       fifo_count;
  logic [FIFO_AW-1:0]    wr_ptr;
  logic [FIFO_AW-1:0]    rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] next_base;
  logic                  req_armed;
  logic                  new_req;
  logic                  rvalid_ok;
  logic                  last_word;
  logic                  room_ok;
  logic                  fifo_wr;
  logic                  fifo_rd;
  logic                  fifo_empty;

  // A held read_req only counts once: it must be seen low after an ack before it can start another frame.
  assign new_req    = bus.read_req && req_armed;
  assign rvalid_ok  = bus.mem_rvalid && (inflight != 9'd0);
  assign last_word  = rvalid_ok && (inflight == 9'd1);
  assign remaining  = 32'(FRAME_WORDS) - 32'(issued);
  assign next_len   = (remaining > 32'(BURST_LEN)) ? 9'(BURST_LEN) : 9'(remaining);
  assign need       = 32'(fifo_count) + 32'(inflight) + 32'(next_len);
  assign room_ok    = (need <= 32'(DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign fifo_wr    = (state == BURST) && rvalid_ok;
  assign fifo_rd    = bus.read_en && !fifo_empty;

  assign bus.read_req_ack = (state == ACK);
  assign state_dbg        = state;

`ifdef FRAME_PINGPONG_EN
  logic pp_sel;

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      pp_sel <= 1'b0;
    end else if (state == ACK) begin
      pp_sel <= ~pp_sel;
    end
  end

  assign next_base = pp_sel ? (BASE_ADDR + ADDR_WIDTH'(FRAME_WORDS)) : BASE_ADDR;
`else
  assign next_base = BASE_ADDR;
`endif

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      issued       <= '0;
      inflight     <= '0;
      base         <= BASE_ADDR;
      req_armed    <= 1'b1;
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= BASE_ADDR;
      bus.mem_len  <= '0;
    end else begin
      if (!bus.read_req) req_armed <= 1'b1;
      case (state)
        IDLE: begin
          if (new_req) state <= ACK;
        end
        ACK: begin
          issued    <= '0;
          inflight  <= '0;
          base      <= next_base;
          req_armed <= 1'b0;
          state     <= FILL;
        end
        FILL: begin
          if (new_req) begin
            bus.mem_req <= 1'b0;
            state       <= ACK;
          end else if (bus.mem_req) begin
            if (bus.mem_gnt) begin
              bus.mem_req <= 1'b0;
              issued      <= issued + CNT_W'(bus.mem_len);
              inflight    <= bus.mem_len;
              state       <= BURST;
            end
          end else if (issued == CNT_W'(FRAME_WORDS)) begin
            state <= DONE;
          end else if (room_ok) begin
            // addr/len only change here, so they stay put for the whole request
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= base + ADDR_WIDTH'(issued);
            bus.mem_len  <= next_len;
          end
        end
        BURST: begin
          if (rvalid_ok) inflight <= inflight - 9'd1;
          if (new_req) state <= last_word ? ACK : DRAIN;
          else if (last_word) state <= FILL;
        end
        DRAIN: begin
          if (rvalid_ok) inflight <= inflight - 9'd1;
          if (last_word) state <= ACK;
        end
        DONE: begin
          if (new_req) state <= ACK;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      bus.read_data <= '0;
      bus.underflow <= 1'b0;
    end else begin
      if (bus.read_en) bus.read_data <= fifo_empty ? '0 : fifo_mem[rd_ptr];
      if (state == ACK) begin
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        fifo_count    <= '0;
        bus.underflow <= 1'b0;
      end else begin
        if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
        if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
        fifo_count <= fifo_count + FC_W'(fifo_wr) - FC_W'(fifo_rd);
        if (bus.read_en && fifo_empty) bus.underflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge video_clk) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= bus.mem_rdata;
  end
endmodule
